// File: rtl/inv_key_expansion_if.sv
// Handshake bundle for inv_key_expansion: key-byte load channel and round-key byte stream.
// master = key source / round-key consumer, slave = the key schedule block.
interface inv_key_expansion_if;
  logic [7:0] key_in;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] rk_out;
  logic       rk_valid;
  logic       rk_ready;
  logic [3:0] rk_round;
  logic       rk_last;
  logic       done;
  logic       busy;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_valid, rk_round, rk_last, done, busy
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_valid, rk_round, rk_last, done, busy
  );
endinterface

// File: rtl/inv_key_expansion.sv
// Byte-serial AES-128 inverse key schedule: loads the round-10 key, streams round keys 10..0.
// Optional INVKEY_ABORT_EN adds an abort input that returns the block to idle.
module inv_key_expansion #(
  parameter int unsigned NR = 10
) (
  input logic clk,
  input logic rst,
`ifdef INVKEY_ABORT_EN
  input logic abort,
`endif
  inv_key_expansion_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StCalc} state_e;

  localparam logic [3:0] RoundInit = 4'(NR);

  state_e     state_q;
  logic [7:0] s_q [16];
  logic [3:0] cnt_q;
  logic [3:0] round_q;
  logic       done_q;

  logic       key_ready_w;
  logic       rk_valid_w;
  logic       key_hs;
  logic       rk_hs;
  logic       abort_req;
  logic [1:0] j;
  logic [1:0] sel;
  logic [7:0] sbox_in;
  logic [7:0] sbox_out;
  logic [7:0] rcon_byte;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_f(input logic [3:0] rnd);
    logic [7:0] v;
    unique case (rnd)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

`ifdef INVKEY_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign key_ready_w = (state_q == StIdle) || (state_q == StLoad);
  assign rk_valid_w  = (state_q == StEmit);
  assign key_hs      = bus.key_valid && key_ready_w;
  assign rk_hs       = rk_valid_w && bus.rk_ready;

  // Sbox phase of CALC: counter 3..0 selects target byte j = 0..3.
  always_comb begin
    j         = 2'd3 - cnt_q[1:0];
    sel       = j + 2'd1;
    sbox_in   = s_q[{2'b11, sel}];
    sbox_out  = sbox_f(sbox_in);
    rcon_byte = (j == 2'd0) ? rcon_f(round_q) : 8'h00;
  end

  assign bus.key_ready = key_ready_w;
  assign bus.rk_valid  = rk_valid_w;
  assign bus.rk_out    = rk_valid_w ? s_q[cnt_q] : 8'h00;
  assign bus.rk_round  = round_q;
  assign bus.rk_last   = rk_valid_w && (cnt_q == 4'd15);
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      round_q <= RoundInit;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) s_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_req && (state_q != StIdle)) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        round_q <= RoundInit;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (key_hs) begin
              s_q[0]  <= bus.key_in;
              cnt_q   <= 4'd1;
              state_q <= StLoad;
            end
          end
          StLoad: begin
            if (key_hs) begin
              s_q[cnt_q] <= bus.key_in;
              cnt_q      <= cnt_q + 4'd1;
              if (cnt_q == 4'd15) state_q <= StEmit;
            end
          end
          StEmit: begin
            if (rk_hs) begin
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd15) begin
                if (round_q == 4'd0) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                  round_q <= RoundInit;
                end else begin
                  state_q <= StCalc;
                  cnt_q   <= 4'd15;
                end
              end
            end
          end
          StCalc: begin
            // Descending k keeps s[k-4] at its old value when it is read.
            if (cnt_q >= 4'd4) begin
              s_q[cnt_q] <= s_q[cnt_q] ^ s_q[cnt_q - 4'd4];
            end else begin
              s_q[{2'b00, j}] <= s_q[{2'b00, j}] ^ sbox_out ^ rcon_byte;
            end
            if (cnt_q == 4'd0) begin
              round_q <= round_q - 4'd1;
              state_q <= StEmit;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench for inv_key_expansion: word-level inverse key schedule model,
// randomized handshakes, mid-run reset and (with INVKEY_ABORT_EN) abort.
module tb_inv_key_expansion;
  localparam logic [127:0] KeyR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KeyR9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KeyR0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inv_key_expansion_if bus ();
`ifdef INVKEY_ABORT_EN
  logic abort = 1'b0;
`endif

  inv_key_expansion #(.NR(10)) dut (
    .clk(clk),
    .rst(rst),
`ifdef INVKEY_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];
  logic [7:0] exp_rk [11][16];
  logic [7:0] cap [176];
  int exp_idx = 0;
  int n_done = 0;
  bit done_next = 1'b0;
  bit stall_prev = 1'b0;
  logic [7:0] stall_val = 8'h00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Sbox by walking the generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] rcon_tb(input int i);
    if (i <= 8) return 8'(1 << (i - 1));
    return (i == 9) ? 8'h1b : 8'h36;
  endfunction

  // Standard word schedule run backwards: w[i-4] = w[i] ^ f(w[i-1]).
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int c = 0; c < 4; c++) w[40 + c] = k[127 - 32 * c -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon_tb(i / 4), 24'h0};
      end
      w[i - 4] = w[i] ^ t;
    end
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int b = 0; b < 4; b++) exp_rk[r][4 * c + b] = w[4 * r + c][31 - 8 * b -: 8];
  endtask

  function automatic logic [127:0] rk_pack(input int r);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = exp_rk[r][i];
    return v;
  endfunction

  function automatic logic [127:0] cap_pack(input int r);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = cap[(10 - r) * 16 + i];
    return v;
  endfunction

  task automatic model_reset();
    exp_idx    = 0;
    done_next  = 1'b0;
    stall_prev = 1'b0;
    n_done     = 0;
    for (int i = 0; i < 176; i++) cap[i] = 8'h00;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_key_ready"}, 128'(bus.key_ready), 128'd1);
    chk({tag, "_rk_valid"}, 128'(bus.rk_valid), 128'd0);
    chk({tag, "_rk_out"}, 128'(bus.rk_out), 128'd0);
    chk({tag, "_rk_round"}, 128'(bus.rk_round), 128'd10);
    chk({tag, "_rk_last"}, 128'(bus.rk_last), 128'd0);
    chk({tag, "_done"}, 128'(bus.done), 128'd0);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
  endtask

  task automatic load_key(input logic [127:0] k, input bit gaps);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < 16 && guard < 200) begin
      bus.key_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.key_in = bus.key_valid ? k[127 - 8 * i -: 8] : 8'($urandom);
      hs = bus.key_valid && bus.key_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    bus.key_valid = 1'b0;
    chk("load_accepted", 128'(i), 128'd16);
  endtask

  // Drive the stream until done, or until exp_idx >= stop_idx with rk_valid == stop_valid.
  task automatic run(input bit rnd, input bit junk, input int stop_idx, input bit stop_valid,
                     output int cycles);
    bit hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < 3000) begin
      bus.rk_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.key_valid = junk && bus.busy;
      bus.key_in    = 8'($urandom);
      @(posedge clk); #1;
      cycles++;
      hit = bus.done || (exp_idx >= stop_idx && bus.rk_valid == stop_valid);
    end
    bus.key_valid = 1'b0;
    chk("run_bound", 128'(cycles >= 3000), 128'd0);
  endtask

  always @(negedge clk) begin : cmp
    int r;
    int b;
    if (!rst) begin
      chk("done", 128'(bus.done), 128'(done_next));
      if (bus.done) n_done++;
      done_next = 1'b0;
      if (bus.rk_valid) begin
        if (exp_idx >= 176) begin
          chk("extra_byte", 128'(bus.rk_valid), 128'd0);
        end else begin
          r = 10 - exp_idx / 16;
          b = exp_idx % 16;
          chk("rk_out", 128'(bus.rk_out), 128'(exp_rk[r][b]));
          chk("rk_round", 128'(bus.rk_round), 128'(r));
          chk("rk_last", 128'(bus.rk_last), 128'(b == 15));
          if (stall_prev) chk("stall_stable", 128'(bus.rk_out), 128'(stall_val));
          if (bus.rk_ready) begin
            cap[exp_idx] = bus.rk_out;
            if (exp_idx == 175) done_next = 1'b1;
            exp_idx++;
            stall_prev = 1'b0;
          end else begin
            stall_prev = 1'b1;
            stall_val  = bus.rk_out;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [127:0] k;
    bus.key_in    = 8'h00;
    bus.key_valid = 1'b0;
    bus.rk_ready  = 1'b0;
    build_sbox();
    model_expand(KeyR10);
    chk("model_rk10", rk_pack(10), KeyR10);
    chk("model_rk9", rk_pack(9), KeyR9);
    chk("model_rk0", rk_pack(0), KeyR0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Back-to-back load, rk_ready held high.
    bus.rk_ready = 1'b1;
    load_key(KeyR10, 1'b0);
    run(1'b0, 1'b0, 999, 1'b0, cyc);
    chk("done_latency", 128'(cyc + 1), 128'd337);
    chk("busy_at_done", 128'(bus.busy), 128'd0);
    chk("key_ready_at_done", 128'(bus.key_ready), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count_a", 128'(n_done), 128'd1);
    chk("cap_r10_a", cap_pack(10), KeyR10);
    chk("cap_r9_a", cap_pack(9), KeyR9);
    chk("cap_r0_a", cap_pack(0), KeyR0);

    // Gaps, random backpressure, junk on the key port during EMIT/CALC.
    model_reset();
    load_key(KeyR10, 1'b1);
    run(1'b1, 1'b1, 999, 1'b0, cyc);
    repeat (2) @(posedge clk);
    #1;
    chk("done_count_b", 128'(n_done), 128'd1);
    chk("cap_r9_b", cap_pack(9), KeyR9);
    chk("cap_r0_b", cap_pack(0), KeyR0);

    for (int it = 0; it < 2; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      model_reset();
      load_key(k, 1'b1);
      run(1'b1, 1'b1, 999, 1'b0, cyc);
      repeat (2) @(posedge clk);
      #1;
      chk("done_count_rand", 128'(n_done), 128'd1);
    end

    // Reset in the CALC that follows round 5.
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    model_reset();
    load_key(k, 1'b1);
    run(1'b1, 1'b0, 96, 1'b0, cyc);
    chk("calc_round5", 128'(bus.rk_round), 128'd5);
    chk("calc_busy", 128'(bus.busy), 128'd1);
    #3;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset("reset_held");
    rst = 1'b0;
    model_expand(KeyR10);
    load_key(KeyR10, 1'b0);
    run(1'b1, 1'b0, 999, 1'b0, cyc);
    repeat (2) @(posedge clk);
    #1;
    chk("done_count_after_rst", 128'(n_done), 128'd1);
    chk("cap_r0_after_rst", cap_pack(0), KeyR0);

`ifdef INVKEY_ABORT_EN
    // Abort during round-7 emission, then a clean reload.
    model_reset();
    load_key(KeyR10, 1'b0);
    run(1'b1, 1'b0, 50, 1'b1, cyc);
    chk("abort_round7", 128'(bus.rk_round), 128'd7);
    abort = 1'b1;
    bus.rk_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_rk_valid", 128'(bus.rk_valid), 128'd0);
    chk("abort_busy", 128'(bus.busy), 128'd0);
    chk("abort_key_ready", 128'(bus.key_ready), 128'd1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 128'(n_done), 128'd0);
    load_key(KeyR10, 1'b1);
    run(1'b1, 1'b0, 999, 1'b0, cyc);
    repeat (2) @(posedge clk);
    #1;
    chk("done_count_after_abort", 128'(n_done), 128'd1);
    chk("cap_r0_after_abort", cap_pack(0), KeyR0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
